// File: rtl/align_sched_if.sv
// align_sched_if
//   Handshake and bus bundle between the alignment scheduler and its neighbours
//   (read-ingest requesters, index builder, seed-lookup engine, result sink).
//   Ports (signal bundle):
//     ref_load/ref_data      new reference pulse and bases
//     ref_out                latched reference to the datapath
//     build_start/build_done index builder handshake
//     index_valid            index is built and current
//     req_valid/req_read     per-requester read available / packed reads
//     req_ready              one-hot grant
//     eng_start/eng_read     lookup start pulse and read under lookup
//     eng_abort              lookup cancel pulse
//     eng_done/eng_hit/eng_index lookup completion and result
//     res_valid/res_id/res_hit/res_index/res_ready tagged result handshake
//   Modports: slave = scheduler side, master = environment side.
interface align_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int READ_W  = 16,
  parameter int REF_W   = 100,
  parameter int IDX_W   = 8
);
  logic                      ref_load;
  logic [REF_W-1:0]          ref_data;
  logic [REF_W-1:0]          ref_out;
  logic                      build_start;
  logic                      build_done;
  logic                      index_valid;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*READ_W-1:0] req_read;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      eng_start;
  logic [READ_W-1:0]         eng_read;
  logic                      eng_abort;
  logic                      eng_done;
  logic                      eng_hit;
  logic [IDX_W-1:0]          eng_index;
  logic                      res_valid;
  logic [ID_W-1:0]           res_id;
  logic                      res_hit;
  logic [IDX_W-1:0]          res_index;
  logic                      res_ready;

  modport slave (
    input  ref_load, ref_data, build_done, req_valid, req_read,
           eng_done, eng_hit, eng_index, res_ready,
    output ref_out, build_start, index_valid, req_ready, eng_start,
           eng_read, eng_abort, res_valid, res_id, res_hit, res_index
  );

  modport master (
    output ref_load, ref_data, build_done, req_valid, req_read,
           eng_done, eng_hit, eng_index, res_ready,
    input  ref_out, build_start, index_valid, req_ready, eng_start,
           eng_read, eng_abort, res_valid, res_id, res_hit, res_index
  );
endinterface

// File: rtl/align_sched.sv
// align_sched
//   Sequences the short-read alignment datapath: a new reference triggers a
//   seed-index build, then the single seed-lookup engine is shared among
//   NUM_REQ requesters with round-robin arbitration. Results come back tagged
//   with the requester ID.
//   Ports:
//     clk    single clock, posedge
//     reset  asynchronous, active-high; clears all state
//     bus    align_sched_if.slave bundle (reference load, index build,
//            request/grant, lookup engine, tagged result)
//   Optional feature macro: ALIGN_SCHED_TIMEOUT_EN
//     defined   -> lookup watchdog of TIMEOUT cycles, eng_abort on expiry and
//                  a miss result (res_hit=0, res_index=all ones)
//     undefined -> LOOKUP waits indefinitely, eng_abort tied to 0
module align_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int READ_W  = 16,
  parameter int REF_W   = 100,
  parameter int IDX_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  align_sched_if.slave     bus
);

  // The round-robin pointer wraps naturally only when NUM_REQ is a power of two.
  if (NUM_REQ != (1 << ID_W) || TIMEOUT < 1) begin : g_bad_cfg
    $error("align_sched: NUM_REQ must equal 2**ID_W and TIMEOUT must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUILD,
    S_READY,
    S_GRANT,
    S_LOOKUP,
    S_RESP
  } state_t;

  state_t            r_state;
  logic [REF_W-1:0]  r_ref_out;
  logic [REF_W-1:0]  r_ref_pend_data;
  logic              r_ref_pend;
  logic              r_build_start;
  logic              r_index_valid;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_id;
  logic              r_eng_start;
  logic [READ_W-1:0] r_eng_read;
  logic              r_res_valid;
  logic              r_res_hit;
  logic [IDX_W-1:0]  r_res_index;

  logic               w_found;
  logic [ID_W-1:0]    w_gnt_id;
  logic [ID_W-1:0]    w_idx;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [READ_W-1:0]  w_gnt_read;
  logic               w_timeout;

  // Round-robin search from r_rr_ptr, evaluated on the live req_valid so a
  // requester that withdraws before the grant cycle is simply not granted.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = r_rr_ptr + ID_W'(i);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx;
      end
    end
  end

  always_comb begin
    w_gnt_read = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (ID_W'(r) == w_gnt_id) begin
        w_gnt_read = bus.req_read[r*READ_W +: READ_W];
      end
    end
  end

  assign w_gnt_oh = w_found ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt_id) : '0;

`ifdef ALIGN_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // r_cnt holds the 1-based index of the current LOOKUP cycle.
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == S_GRANT && w_found) begin
      r_cnt <= CNT_W'(1);
    end else if (r_state == S_LOOKUP) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A coincident eng_done wins over the watchdog.
  assign w_timeout     = (r_state == S_LOOKUP) && (r_cnt == CNT_W'(TIMEOUT)) && !bus.eng_done;
  assign bus.eng_abort = w_timeout;
`else
  assign w_timeout     = 1'b0;
  assign bus.eng_abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_ref_out       <= '0;
      r_ref_pend_data <= '0;
      r_ref_pend      <= 1'b0;
      r_build_start   <= 1'b0;
      r_index_valid   <= 1'b0;
      r_rr_ptr        <= '0;
      r_id            <= '0;
      r_eng_start     <= 1'b0;
      r_eng_read      <= '0;
      r_res_valid     <= 1'b0;
      r_res_hit       <= 1'b0;
      r_res_index     <= '0;
    end else begin
      r_build_start <= 1'b0;
      r_eng_start   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.ref_load) begin
            r_ref_out     <= bus.ref_data;
            r_build_start <= 1'b1;
            r_state       <= S_BUILD;
          end
        end

        S_BUILD: begin
          // A fresh reference supersedes any build_done for the old one.
          if (bus.ref_load) begin
            r_ref_out     <= bus.ref_data;
            r_build_start <= 1'b1;
          end else if (bus.build_done) begin
            r_index_valid <= 1'b1;
            r_state       <= S_READY;
          end
        end

        S_READY: begin
          if (bus.ref_load || r_ref_pend) begin
            r_ref_out     <= bus.ref_load ? bus.ref_data : r_ref_pend_data;
            r_ref_pend    <= 1'b0;
            r_build_start <= 1'b1;
            r_index_valid <= 1'b0;
            r_state       <= S_BUILD;
          end else if (|bus.req_valid) begin
            r_state <= S_GRANT;
          end
        end

        S_GRANT: begin
          if (bus.ref_load) begin
            r_ref_pend      <= 1'b1;
            r_ref_pend_data <= bus.ref_data;
          end
          if (w_found) begin
            r_id        <= w_gnt_id;
            r_eng_read  <= w_gnt_read;
            r_rr_ptr    <= w_gnt_id + 1'b1;
            r_eng_start <= 1'b1;
            r_state     <= S_LOOKUP;
          end else begin
            r_state <= S_READY;
          end
        end

        S_LOOKUP: begin
          // Reference changes are deferred so the in-flight lookup sees a
          // stable ref_out; the newest one is kept.
          if (bus.ref_load) begin
            r_ref_pend      <= 1'b1;
            r_ref_pend_data <= bus.ref_data;
          end
          if (bus.eng_done) begin
            r_res_hit   <= bus.eng_hit;
            r_res_index <= bus.eng_index;
            r_res_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            r_res_hit   <= 1'b0;
            r_res_index <= '1;
            r_res_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end

        S_RESP: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            if (bus.ref_load || r_ref_pend) begin
              r_ref_out     <= bus.ref_load ? bus.ref_data : r_ref_pend_data;
              r_ref_pend    <= 1'b0;
              r_build_start <= 1'b1;
              r_index_valid <= 1'b0;
              r_state       <= S_BUILD;
            end else begin
              r_state <= S_READY;
            end
          end else if (bus.ref_load) begin
            r_ref_pend      <= 1'b1;
            r_ref_pend_data <= bus.ref_data;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ref_out     = r_ref_out;
  assign bus.build_start = r_build_start;
  assign bus.index_valid = r_index_valid;
  assign bus.req_ready   = (r_state == S_GRANT) ? w_gnt_oh : '0;
  assign bus.eng_start   = r_eng_start;
  assign bus.eng_read    = r_eng_read;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_id      = r_id;
  assign bus.res_hit     = r_res_hit;
  assign bus.res_index   = r_res_index;

endmodule

// File: tb/tb_align_sched.sv
// tb_align_sched
//   Directed bench for align_sched in its default build (no watchdog):
//   reference load and index build, round-robin service of requesters 1 and 3,
//   result back-pressure, deferred reference reload, grant withdrawal and
//   asynchronous reset in the middle of a lookup.
module tb_align_sched;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  align_sched_if bus ();

  align_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rd(input int id);
    return 16'h1111 * 16'(id);
  endfunction

  // Entry: READY cycle with req_valid already driven. Exit: READY cycle.
  task automatic serve(input int id, input logic hit, input logic [7:0] idx, input int hold);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    nxt(); #1;
    chk("grant", bus.req_ready, oh);
    nxt(); #1;
    chk("eng_start", bus.eng_start, 1);
    chk("eng_read", bus.eng_read, rd(id));
    chk("req_ready_lookup", bus.req_ready, 0);
    bus.eng_done = 1'b1; bus.eng_hit = hit; bus.eng_index = idx;
    nxt();
    bus.eng_done = 1'b0; bus.eng_hit = 1'b0; bus.eng_index = 8'h00;
    #1;
    chk("result", {bus.res_valid, bus.res_id, bus.res_hit, bus.res_index},
        {1'b1, 2'(id), hit, idx});
    for (int k = 0; k < hold; k++) begin
      nxt(); #1;
      chk("result_hold", {bus.res_valid, bus.res_id, bus.res_hit, bus.res_index, bus.req_ready, bus.eng_start},
          {1'b1, 2'(id), hit, idx, 4'b0000, 1'b0});
    end
    bus.res_ready = 1'b1;
    nxt();
    bus.res_ready = 1'b0;
    #1;
    chk("result_clear", {bus.res_valid, bus.req_ready}, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.ref_load   = 1'b0;
    bus.ref_data   = '0;
    bus.build_done = 1'b0;
    bus.req_valid  = 4'b0000;
    bus.req_read   = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    bus.eng_done   = 1'b0;
    bus.eng_hit    = 1'b0;
    bus.eng_index  = 8'h00;
    bus.res_ready  = 1'b0;

    // Reset values
    #2 reset = 1'b1;
    #1;
    chk("reset_outs", {bus.build_start, bus.index_valid, bus.req_ready, bus.eng_start, bus.eng_abort,
                       bus.res_valid, bus.res_id, bus.res_hit, bus.res_index, bus.eng_read}, 0);
    chk("reset_ref_out", bus.ref_out, 0);
    nxt();
    nxt();
    reset = 1'b0;

    // Reference load and build
    bus.ref_load = 1'b1; bus.ref_data = 100'h5;
    nxt();
    bus.ref_load = 1'b0; bus.ref_data = '0;
    #1;
    chk("build_start_pulse", bus.build_start, 1);
    chk("ref_out_5", bus.ref_out, 100'h5);
    chk("index_valid_building", bus.index_valid, 0);
    nxt(); #1;
    chk("build_start_single", bus.build_start, 0);
    repeat (8) nxt();
    bus.build_done = 1'b1;
    #1;
    chk("index_valid_before_done", bus.index_valid, 0);
    nxt();
    bus.build_done = 1'b0;
    #1;
    chk("index_valid_set", bus.index_valid, 1);

    // Round robin between requesters 1 and 3, with back-pressure on the last
    bus.req_valid = 4'b1010;
    #1;
    chk("no_grant_in_ready", bus.req_ready, 0);
    serve(1, 1'b1, 8'h22, 0);
    serve(3, 1'b1, 8'h22, 0);
    serve(1, 1'b0, 8'h07, 0);
    serve(3, 1'b1, 8'h5A, 5);

    // Reference load during LOOKUP is deferred until after the result
    nxt(); #1;
    chk("grant_reload", bus.req_ready, 4'b0010);
    nxt();
    bus.ref_load = 1'b1; bus.ref_data = 100'hABC;
    nxt();
    bus.ref_load = 1'b0; bus.ref_data = '0;
    #1;
    chk("ref_held_lookup", {bus.ref_out, bus.build_start, bus.index_valid}, {100'h5, 1'b0, 1'b1});
    bus.eng_done = 1'b1; bus.eng_hit = 1'b1; bus.eng_index = 8'h33;
    nxt();
    bus.eng_done = 1'b0; bus.eng_hit = 1'b0; bus.eng_index = 8'h00;
    #1;
    chk("result_reload", {bus.res_valid, bus.res_id, bus.res_hit, bus.res_index}, {1'b1, 2'd1, 1'b1, 8'h33});
    bus.res_ready = 1'b1;
    nxt();
    bus.res_ready = 1'b0;
    #1;
    chk("rebuild_start", {bus.build_start, bus.index_valid, bus.res_valid}, {1'b1, 1'b0, 1'b0});
    chk("rebuild_ref_out", bus.ref_out, 100'hABC);
    chk("no_grant_build", bus.req_ready, 0);
    repeat (3) nxt();
    #1;
    chk("index_invalid_rebuild", {bus.index_valid, bus.build_start, bus.req_ready}, 0);
    bus.build_done = 1'b1;
    nxt();
    bus.build_done = 1'b0;
    #1;
    chk("index_valid_rebuilt", bus.index_valid, 1);

    // ref_load in READY wins over pending requests
    bus.ref_load = 1'b1; bus.ref_data = 100'h7;
    nxt();
    bus.ref_load = 1'b0;
    #1;
    chk("ready_reload", {bus.req_ready, bus.build_start, bus.index_valid}, {4'b0000, 1'b1, 1'b0});
    chk("ready_reload_ref", bus.ref_out, 100'h7);
    // build_done coinciding with another ref_load is discarded
    bus.ref_load = 1'b1; bus.ref_data = 100'h9; bus.build_done = 1'b1;
    nxt();
    bus.ref_load = 1'b0; bus.ref_data = '0; bus.build_done = 1'b0;
    #1;
    chk("build_done_discarded", {bus.index_valid, bus.build_start}, {1'b0, 1'b1});
    chk("ref_out_9", bus.ref_out, 100'h9);
    bus.build_done = 1'b1;
    nxt();
    bus.build_done = 1'b0;
    #1;
    chk("index_valid_after_9", bus.index_valid, 1);

    // No watchdog in default build: lookup waits forever
    nxt(); #1;
    chk("grant_3_wait", bus.req_ready, 4'b1000);
    nxt(); #1;
    chk("eng_read_wait", {bus.eng_start, bus.eng_read}, {1'b1, 16'h3333});
    for (int c = 0; c < 200; c++) begin
      nxt(); #1;
      chk("lookup_wait", {bus.res_valid, bus.eng_abort}, 0);
    end

    // Asynchronous reset in the middle of LOOKUP
    reset = 1'b1;
    #1;
    chk("midreset_outs", {bus.build_start, bus.index_valid, bus.req_ready, bus.eng_start, bus.eng_abort,
                          bus.res_valid, bus.res_id, bus.res_hit, bus.res_index, bus.eng_read}, 0);
    chk("midreset_ref_out", bus.ref_out, 0);
    nxt();
    reset = 1'b0;
    bus.build_done = 1'b1; bus.eng_done = 1'b1;
    for (int c = 0; c < 4; c++) begin
      nxt(); #1;
      chk("idle_ignores", {bus.req_ready, bus.index_valid, bus.eng_start, bus.build_start, bus.res_valid}, 0);
    end
    bus.build_done = 1'b0; bus.eng_done = 1'b0;
    bus.ref_load = 1'b1; bus.ref_data = 100'h11;
    nxt();
    bus.ref_load = 1'b0; bus.ref_data = '0;
    #1;
    chk("post_reset_build", {bus.build_start, bus.ref_out}, {1'b1, 100'h11});
    bus.build_done = 1'b1;
    nxt();
    bus.build_done = 1'b0;
    #1;
    chk("post_reset_index", bus.index_valid, 1);

    // Requester withdraws in the grant cycle: no grant, pointer unchanged
    nxt();
    bus.req_valid = 4'b0000;
    #1;
    chk("withdrawn_no_grant", bus.req_ready, 0);
    nxt(); #1;
    chk("withdrawn_no_start", bus.eng_start, 0);
    bus.req_valid = 4'b1010;
    nxt(); #1;
    chk("grant_after_reset_rr0", bus.req_ready, 4'b0010);
    nxt(); #1;
    chk("start_after_reset", {bus.eng_start, bus.eng_read}, {1'b1, 16'h1111});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
